// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two cache-line requesters, the arbiter and the shared memory bus.
// The arbiter connects through the master modport; the requesters and memory side use slave.
interface mem_bus_arbiter_if #(
    parameter int unsigned BUS_SIZE  = 16,
    parameter int unsigned ADDR_SIZE = 15
);
    // Requester side
    logic [1:0]             req_valid;
    logic [1:0]             req_write;
    logic [2*ADDR_SIZE-1:0] req_addr;
    logic [2*BUS_SIZE-1:0]  req_wdata;
    logic [1:0]             wbeat;
    logic [BUS_SIZE-1:0]    rdata;
    logic [1:0]             rvalid;
    logic [1:0]             done;
    logic [1:0]             err;

    // Memory side
    logic [ADDR_SIZE-1:0]   mem_address;
    logic [1:0]             mem_cmd_out;
    logic                   mem_cmd_oe;
    logic [BUS_SIZE-1:0]    mem_data_out;
    logic                   mem_data_oe;
    logic [1:0]             mem_cmd_in;
    logic [BUS_SIZE-1:0]    mem_data_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_cmd_in, mem_data_in,
        output wbeat, rdata, rvalid, done, err,
        output mem_address, mem_cmd_out, mem_cmd_oe, mem_data_out, mem_data_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_cmd_in, mem_data_in,
        input  wbeat, rdata, rvalid, done, err,
        input  mem_address, mem_cmd_out, mem_cmd_oe, mem_data_out, mem_data_oe
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter granting one of two requesters a whole cache-line
// transfer (fill or write-back) on a shared memory bus, one transfer in flight at a time.
// Optional response watchdog: define MEM_BUS_ARBITER_TIMEOUT_EN to abort a transfer with
// done+err after TIMEOUT_CYCLES cycles without a RESPONSE; otherwise err is tied low.
module mem_bus_arbiter #(
    parameter int unsigned BUS_SIZE       = 16,
    parameter int unsigned ADDR_SIZE      = 15,
    parameter int unsigned BEATS          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);
    localparam int unsigned CntW  = $clog2(BEATS + 1);
    localparam int unsigned WLast = BEATS - 1;
    // Beat 0 of a fill arrives in WAIT_RESP, so RDATA only carries BEATS-1 beats.
    localparam int unsigned RLast = (BEATS > 1) ? BEATS - 2 : 0;

    localparam logic [1:0] CmdNop   = 2'd0;
    localparam logic [1:0] CmdResp  = 2'd1;
    localparam logic [1:0] CmdRead  = 2'd2;
    localparam logic [1:0] CmdWrite = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StWaitResp,
        StRdata,
        StDone
    } state_e;

    state_e               state_q;
    logic                 winner_q;
    logic                 write_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [CntW-1:0]      cnt_q;
    logic                 last_grant_q;
    logic                 pick;
    logic                 resp;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0]      tmo_q;
    logic                 err_q;
`endif

    // Round-robin pick: a lone request wins, a tie goes to the index not granted last.
    always_comb begin
        pick = bus.req_valid[1];
        if (&bus.req_valid) begin
            pick = ~last_grant_q;
        end
        resp = (bus.mem_cmd_in == CmdResp);
    end

    // Transfer sequencing FSM with grant history and beat counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            winner_q     <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
            tmo_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.req_valid) begin
                        winner_q <= pick;
                        write_q  <= bus.req_write[pick];
                        addr_q   <= pick ? bus.req_addr[2*ADDR_SIZE-1:ADDR_SIZE]
                                         : bus.req_addr[ADDR_SIZE-1:0];
                        state_q  <= StCmd;
                    end
                end
                StCmd: begin
                    cnt_q   <= '0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                    state_q <= write_q ? StWdata : StWaitResp;
                end
                StWdata: begin
                    if (cnt_q == CntW'(WLast)) begin
                        state_q <= StWaitResp;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitResp: begin
                    if (resp) begin
                        if (write_q || BEATS == 1) begin
                            state_q <= StDone;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StRdata;
                        end
                    end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                    else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
`endif
                end
                StRdata: begin
                    // Memory streams the line back to back; its command wires are not re-checked.
                    if (cnt_q == CntW'(RLast)) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    last_grant_q <= winner_q;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                    err_q        <= 1'b0;
`endif
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bus and requester outputs decoded from the registered state; idle values are all zero.
    always_comb begin
        bus.wbeat        = '0;
        bus.rvalid       = '0;
        bus.done         = '0;
        bus.err          = '0;
        bus.rdata        = '0;
        bus.mem_address  = '0;
        bus.mem_cmd_out  = CmdNop;
        bus.mem_cmd_oe   = 1'b0;
        bus.mem_data_out = '0;
        bus.mem_data_oe  = 1'b0;
        unique case (state_q)
            StCmd: begin
                bus.mem_cmd_oe  = 1'b1;
                bus.mem_cmd_out = write_q ? CmdWrite : CmdRead;
                bus.mem_address = addr_q;
            end
            StWdata: begin
                bus.mem_cmd_oe      = 1'b1;
                bus.mem_cmd_out     = CmdWrite;
                bus.mem_address     = addr_q;
                bus.mem_data_oe     = 1'b1;
                bus.mem_data_out    = winner_q ? bus.req_wdata[2*BUS_SIZE-1:BUS_SIZE]
                                               : bus.req_wdata[BUS_SIZE-1:0];
                bus.wbeat[winner_q] = 1'b1;
            end
            StWaitResp: begin
                // The RESPONSE cycle of a fill already carries beat 0.
                if (resp && !write_q) begin
                    bus.rdata            = bus.mem_data_in;
                    bus.rvalid[winner_q] = 1'b1;
                end
            end
            StRdata: begin
                bus.rdata            = bus.mem_data_in;
                bus.rvalid[winner_q] = 1'b1;
            end
            StDone: begin
                bus.done[winner_q] = 1'b1;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
                bus.err[winner_q]  = err_q;
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a reactive memory/requester model drives the bus and a
// queue of expected beats is filled when each request is posted and drained as beats appear.
module tb_mem_bus_arbiter;
    localparam logic [1:0] CmdNop   = 2'd0;
    localparam logic [1:0] CmdResp  = 2'd1;
    localparam logic [1:0] CmdRead  = 2'd2;
    localparam logic [1:0] CmdWrite = 2'd3;

    logic clk;
    logic reset;
    int   cyc;
    int   vecs;
    int   miscompares;
    logic [15:0] exp_q[$];

    mem_bus_arbiter_if #(.BUS_SIZE(16), .ADDR_SIZE(15)) bus ();

    mem_bus_arbiter #(
        .BUS_SIZE      (16),
        .ADDR_SIZE     (15),
        .BEATS         (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed time %0t required end", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {5'd0, bus.wbeat, bus.rvalid, bus.done, bus.err, bus.rdata, bus.mem_address,
                bus.mem_cmd_out, bus.mem_cmd_oe, bus.mem_data_out, bus.mem_data_oe};
    endfunction

    task automatic set_wdata(input int idx, input logic [15:0] v);
        if (idx == 0) bus.req_wdata[15:0] = v;
        else bus.req_wdata[31:16] = v;
    endtask

    task automatic post(input int idx, input bit wr, input logic [14:0] addr);
        bus.req_valid[idx] = 1'b1;
        bus.req_write[idx] = wr;
        if (idx == 0) bus.req_addr[14:0] = addr;
        else bus.req_addr[29:15] = addr;
    endtask

    // Serves one granted line transfer; memory answers 'delay' cycles into WAIT_RESP.
    task automatic do_xfer(input int idx, input bit wr, input logic [14:0] addr, input int delay,
                           input logic [15:0] base, input logic [15:0] step, input bit drop,
                           output int cmd_cyc, output int done_cyc);
        int mem_cnt, rbeat, beat_k, cmd_n, wcmd_n, resp_cyc, last_rv_cyc;
        bit cmd_seen, responded, fin;
        mem_cnt = 0; rbeat = 0; beat_k = 0; cmd_n = 0; wcmd_n = 0;
        resp_cyc = -100; last_rv_cyc = -100; cmd_cyc = -100; done_cyc = -100;
        cmd_seen = 0; responded = 0; fin = 0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(16'(base + step * 16'(k)));
        for (int c = 0; c < 300 && !fin; c++) begin
            @(posedge clk);
            #1;
            set_wdata(idx, 16'(base + step * 16'(beat_k)));
            bus.mem_cmd_in  = CmdNop;
            bus.mem_data_in = '0;
            if (responded && !wr && rbeat < 8) begin
                bus.mem_data_in = 16'(base + step * 16'(rbeat));
                rbeat++;
            end
            if (bus.mem_cmd_oe && !bus.mem_data_oe) begin
                cmd_seen = 1;
                mem_cnt  = 0;
                if (drop) bus.req_valid[idx] = 1'b0;
            end else if (cmd_seen && !bus.mem_cmd_oe && !responded) begin
                mem_cnt++;
                if (mem_cnt == delay) begin
                    bus.mem_cmd_in  = CmdResp;
                    bus.mem_data_in = wr ? 16'h0 : base;
                    responded       = 1;
                    rbeat           = 1;
                    resp_cyc        = cyc;
                end
            end
            @(negedge clk);
            if (bus.mem_cmd_oe && !bus.mem_data_oe) begin
                cmd_n++;
                cmd_cyc = cyc;
                check("cmd_code", bus.mem_cmd_out, wr ? CmdWrite : CmdRead);
                check("cmd_addr", bus.mem_address, addr);
            end
            if (bus.mem_cmd_oe && bus.mem_cmd_out == CmdWrite) wcmd_n++;
            if (bus.wbeat != 2'b00) begin
                check("wbeat_sel", bus.wbeat, 64'(1 << idx));
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("wdata", bus.mem_data_out, exp_q.pop_front());
                beat_k++;
            end
            if (bus.rvalid != 2'b00) begin
                check("rvalid_sel", bus.rvalid, 64'(1 << idx));
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("rdata", bus.rdata, exp_q.pop_front());
                last_rv_cyc = cyc;
            end
            if (bus.done != 2'b00) begin
                check("done_sel", bus.done, 64'(1 << idx));
                check("done_err", bus.err, 0);
                check("sb_left", exp_q.size(), 0);
                check("cmd_once", cmd_n, 1);
                if (wr) begin
                    check("write_cmd_len", wcmd_n, 9);
                    check("write_done_after_resp", cyc - resp_cyc, 1);
                end else begin
                    check("read_done_after_beat7", cyc - last_rv_cyc, 1);
                end
                bus.req_valid[idx] = 1'b0;
                done_cyc = cyc;
                fin = 1;
            end
        end
        if (!fin) begin
            check("xfer_timeout", 0, 1);
            bus.req_valid[idx] = 1'b0;
        end
        exp_q.delete();
    endtask

    initial begin
        int c0, d0, c1, d1, n, cmd_c, stuck;
        bit got;
        vecs = 0; miscompares = 0; cyc = 0;
        reset = 1'b0;
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_cmd_in = CmdNop; bus.mem_data_in = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", outs(), 0);
        reset = 1'b1;

        // Single fill, memory answers 4 cycles after CMD
        @(negedge clk);
        post(0, 0, 15'h0012);
        do_xfer(0, 0, 15'h0012, 4, 16'h1111, 16'h1111, 0, c0, d0);

        // Single write-back at top address
        @(negedge clk);
        post(1, 1, 15'h7FFF);
        do_xfer(1, 1, 15'h7FFF, 3, 16'hA000, 16'h0001, 0, c0, d0);

        // Tie after requester 1 was last: requester 0 first, then 1 right behind
        @(negedge clk);
        post(0, 0, 15'h0100);
        post(1, 1, 15'h0200);
        do_xfer(0, 0, 15'h0100, 2, 16'h0101, 16'h0202, 0, c0, d0);
        do_xfer(1, 1, 15'h0200, 1, 16'hC000, 16'h0011, 0, c1, d1);
        check("tie_second_cmd_gap", c1 - d0, 2);

        // Requester 0 drops valid mid-transfer, then a tie goes to requester 1
        @(negedge clk);
        post(0, 0, 15'h0033);
        do_xfer(0, 0, 15'h0033, 5, 16'h3000, 16'h0100, 1, c0, d0);
        post(0, 0, 15'h0044);
        post(1, 1, 15'h0055);
        do_xfer(1, 1, 15'h0055, 2, 16'h5500, 16'h0003, 0, c1, d1);
        do_xfer(0, 0, 15'h0044, 1, 16'h4400, 16'h0005, 0, c0, d0);

        // Reset asserted during write beat 3
        @(negedge clk);
        post(1, 1, 15'h0AAA);
        set_wdata(1, 16'hB000);
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (bus.wbeat[1]) n++;
        end
        check("rst_reached_beat", n, 3);
        @(posedge clk);
        #2;
        check("rst_in_beat3", bus.wbeat, 2'b10);
        reset = 1'b0;
        #1;
        check("rst_async_outputs", outs(), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_held_outputs", outs(), 0);
        end
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        // Grant history reset: a tie goes to requester 0 again
        @(negedge clk);
        post(0, 0, 15'h0600);
        post(1, 1, 15'h0700);
        do_xfer(0, 0, 15'h0600, 3, 16'h6000, 16'h0010, 0, c0, d0);
        do_xfer(1, 1, 15'h0700, 2, 16'h7000, 16'h0020, 0, c1, d1);

        // Memory never answers
        @(negedge clk);
        post(0, 0, 15'h0077);
        cmd_c = -1000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_cmd_oe) begin
                cmd_c = cyc;
                break;
            end
        end
        check("nresp_cmd_seen", bus.mem_cmd_out, CmdRead);
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (bus.done != 2'b00) got = 1;
        end
        check("tmo_done", bus.done, 2'b01);
        check("tmo_err", bus.err, 2'b01);
        check("tmo_rvalid", bus.rvalid, 2'b00);
        check("tmo_when", cyc - cmd_c, 17);
        bus.req_valid = '0;
`else
        got = 0;
        stuck = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.done != 2'b00 || bus.rvalid != 2'b00 || bus.err != 2'b00 || bus.mem_cmd_oe)
                stuck++;
        end
        check("no_tmo_quiet", stuck, 0);
        check("no_tmo_cmd_seen", got || cmd_c >= 0, 1);
        bus.req_valid = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`endif
        @(negedge clk);
        check("final_idle", outs(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
